// File: rtl/ca_seek_scheduler_pkg.sv
// Shared code-phase constants, scheduler state encoding and the modular
// code-shift adder used when stepping between search bins.
package ca_seek_scheduler_pkg;

  localparam int unsigned CODE_SHIFT_MAX_DEFAULT = 16799;
  localparam int unsigned SHIFT_WIDTH            = 15;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEEK    = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_DWELL   = 3'd3,
    ST_ADVANCE = 3'd4
  } state_t;

  // Operands are both below period, so one conditional subtraction suffices.
  function automatic logic [SHIFT_WIDTH-1:0] wrap_shift(
    input logic [SHIFT_WIDTH-1:0] base,
    input logic [SHIFT_WIDTH-1:0] inc,
    input logic [SHIFT_WIDTH:0]   period
  );
    logic [SHIFT_WIDTH:0] sum;
    sum = {1'b0, base} + {1'b0, inc};
    if (sum >= period) begin
      sum = sum - period;
    end
    return sum[SHIFT_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/ca_seek_scheduler_dwell_counter.sv
// Loadable down-counter; terminal flags the final enabled cycle of a dwell.
module ca_seek_scheduler_dwell_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             count_en,
  output logic             terminal
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count_en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign terminal = count_en && (count == ONE);

endmodule

// File: rtl/ca_seek_scheduler.sv
// C/A code-phase search scheduler: steps the upsampler through a sweep of
// code-shift bins, dwelling a fixed number of enabled samples on each.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | waiting for start; targets and bin index hold
// ST_SEEK    | seek_en raised, covers upsampler enable pipeline
// ST_SETTLE  | waiting for upsampler to land on seek_target
// ST_DWELL   | acc_enable high for the configured dwell length
// ST_ADVANCE | finish sweep or step target to the next bin
module ca_seek_scheduler
  import ca_seek_scheduler_pkg::*;
#(
  parameter int unsigned CODE_SHIFT_MAX = CODE_SHIFT_MAX_DEFAULT,
  parameter int unsigned DWELL_WIDTH    = 16,
  parameter int unsigned BIN_WIDTH      = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [14:0]            start_shift,
  input  logic [14:0]            step,
  input  logic [BIN_WIDTH-1:0]   num_bins,
  input  logic [DWELL_WIDTH-1:0] dwell_len,
  input  logic                   up_seeking,
  input  logic [14:0]            up_code_shift,
  output logic                   seek_en,
  output logic [14:0]            seek_target,
  output logic                   acc_enable,
  output logic                   bin_start,
  output logic                   bin_done,
  output logic [BIN_WIDTH-1:0]   bin_index,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_error
);

  localparam logic [14:0]            SHIFT_MAX = 15'(CODE_SHIFT_MAX);
  localparam logic [15:0]            PERIOD    = 16'(CODE_SHIFT_MAX + 1);
  localparam logic [DWELL_WIDTH-1:0] DWELL_ONE = {{(DWELL_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state;
  logic [14:0]            step_q;
  logic [BIN_WIDTH-1:0]   last_bin_q;
  logic [DWELL_WIDTH-1:0] dwell_q;

  logic cfg_ok;
  logic settled;
  logic dwell_last;

  assign cfg_ok  = (start_shift <= SHIFT_MAX) && (step != '0) && (step <= SHIFT_MAX);
  assign settled = !up_seeking && (up_code_shift == seek_target);

  ca_seek_scheduler_dwell_counter #(
    .WIDTH(DWELL_WIDTH)
  ) u_dwell_counter (
    .clk       (clk),
    .reset     (reset),
    .load      ((state == ST_SETTLE) && settled),
    .load_value(dwell_q),
    .count_en  (state == ST_DWELL),
    .terminal  (dwell_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      seek_en     <= 1'b0;
      seek_target <= '0;
      acc_enable  <= 1'b0;
      bin_start   <= 1'b0;
      bin_done    <= 1'b0;
      bin_index   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cfg_error   <= 1'b0;
      step_q      <= '0;
      last_bin_q  <= '0;
      dwell_q     <= '0;
    end else begin
      bin_start <= 1'b0;
      bin_done  <= 1'b0;
      done      <= 1'b0;
      cfg_error <= 1'b0;
      if (abort) begin
        state      <= ST_IDLE;
        seek_en    <= 1'b0;
        acc_enable <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              if (cfg_ok) begin
                step_q      <= step;
                last_bin_q  <= (num_bins == '0) ? '0 : num_bins - 1'b1;
                dwell_q     <= (dwell_len == '0) ? DWELL_ONE : dwell_len;
                seek_target <= start_shift;
                bin_index   <= '0;
                seek_en     <= 1'b1;
                busy        <= 1'b1;
                state       <= ST_SEEK;
              end else begin
                cfg_error <= 1'b1;
              end
            end
          end
          ST_SEEK: begin
            state <= ST_SETTLE;
          end
          ST_SETTLE: begin
            if (settled) begin
              seek_en    <= 1'b0;
              acc_enable <= 1'b1;
              bin_start  <= 1'b1;
              state      <= ST_DWELL;
            end
          end
          ST_DWELL: begin
            if (dwell_last) begin
              acc_enable <= 1'b0;
              bin_done   <= 1'b1;
              state      <= ST_ADVANCE;
            end
          end
          ST_ADVANCE: begin
            if (bin_index == last_bin_q) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              bin_index   <= bin_index + 1'b1;
              seek_target <= wrap_shift(seek_target, step_q, PERIOD);
              seek_en     <= 1'b1;
              state       <= ST_SEEK;
            end
          end
          default: begin
            seek_en    <= 1'b0;
            acc_enable <= 1'b0;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ca_seek_scheduler.sv
// Scoreboard bench for ca_seek_scheduler with an idealised upsampler whose
// settle latency is randomised.
module tb_ca_seek_scheduler;

  localparam int PERIOD  = 16800;
  localparam int EV_BIN  = 0;
  localparam int EV_DONE = 1;
  localparam int EV_CFG  = 2;

  typedef struct {
    int kind;
    int idx;
    int target;
    int dwell;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [14:0] start_shift = '0;
  logic [14:0] step = '0;
  logic [9:0]  num_bins = '0;
  logic [15:0] dwell_len = '0;
  logic        up_seeking = 1'b0;
  logic [14:0] up_code_shift = '0;
  logic        seek_en;
  logic [14:0] seek_target;
  logic        acc_enable;
  logic        bin_start;
  logic        bin_done;
  logic [9:0]  bin_index;
  logic        busy;
  logic        done;
  logic        cfg_error;

  int n_checks = 0;
  int n_fail   = 0;
  ev_t exp_q[$];

  ca_seek_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .start_shift  (start_shift),
    .step         (step),
    .num_bins     (num_bins),
    .dwell_len    (dwell_len),
    .up_seeking   (up_seeking),
    .up_code_shift(up_code_shift),
    .seek_en      (seek_en),
    .seek_target  (seek_target),
    .acc_enable   (acc_enable),
    .bin_start    (bin_start),
    .bin_done     (bin_done),
    .bin_index    (bin_index),
    .busy         (busy),
    .done         (done),
    .cfg_error    (cfg_error)
  );

  always #5 clk = ~clk;

  // Ideal upsampler: notices a rising seek_en one cycle late, then lands on
  // the requested target after a random delay.
  int   up_dmin = 0;
  int   up_dmax = 3;
  int   up_cnt  = 0;
  logic seek_en_d = 1'b0;

  always @(posedge clk) begin
    seek_en_d <= seek_en;
    if (seek_en && !seek_en_d) begin
      up_seeking <= 1'b1;
      up_cnt     <= int'($urandom_range(up_dmax, up_dmin));
    end else if (up_seeking) begin
      if (up_cnt == 0) begin
        up_seeking    <= 1'b0;
        up_code_shift <= seek_target;
      end else begin
        up_cnt <= up_cnt - 1;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: unexpected event at %0t", name, $time);
  endtask

  // Monitor: pops the scoreboard whenever the DUT reports an event.
  bit bin_active = 1'b0;
  int run_len    = 0;
  int cur_dwell  = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (bin_start) begin
        if (exp_q.size() == 0 || exp_q[0].kind != EV_BIN) begin
          flag("bin_start");
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          check("bin_index", int'(bin_index), e.idx);
          check("seek_target", int'(seek_target), e.target);
          bin_active = 1'b1;
          cur_dwell  = e.dwell;
          run_len    = 0;
        end
      end
      if (acc_enable) begin
        if (!bin_active) flag("acc_enable_outside_bin");
        else run_len++;
      end
      if (bin_done) begin
        if (!bin_active || cur_dwell == 0) flag("bin_done");
        else check("dwell_cycles", run_len, cur_dwell);
        bin_active = 1'b0;
      end else if (bin_active && !busy) begin
        if (cur_dwell != 0) flag("bin_done_missing");
        bin_active = 1'b0;
      end
      if (done) begin
        if (exp_q.size() == 0 || exp_q[0].kind != EV_DONE) flag("done");
        else void'(exp_q.pop_front());
      end
      if (cfg_error) begin
        if (exp_q.size() == 0 || exp_q[0].kind != EV_CFG) flag("cfg_error");
        else void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_seek_en"}, int'(seek_en), 0);
    check({tag, "_seek_target"}, int'(seek_target), 0);
    check({tag, "_acc_enable"}, int'(acc_enable), 0);
    check({tag, "_bin_start"}, int'(bin_start), 0);
    check({tag, "_bin_done"}, int'(bin_done), 0);
    check({tag, "_bin_index"}, int'(bin_index), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_cfg_error"}, int'(cfg_error), 0);
  endtask

  task automatic set_cfg(input int ss, input int st, input int nb, input int dl);
    start_shift = 15'(ss);
    step        = 15'(st);
    num_bins    = 10'(nb);
    dwell_len   = 16'(dl);
  endtask

  // Reference model: bin i lands on (ss + i*st) mod period for max(dl,1) cycles.
  task automatic expect_sweep(input int ss, input int st, input int nb, input int dl);
    int nbe;
    int dle;
    nbe = (nb == 0) ? 1 : nb;
    dle = (dl == 0) ? 1 : dl;
    for (int i = 0; i < nbe; i++) begin
      exp_q.push_back('{EV_BIN, i, (ss + i * st) % PERIOD, dle});
    end
    exp_q.push_back('{EV_DONE, 0, 0, 0});
  endtask

  task automatic run_sweep(input int ss, input int st, input int nb, input int dl,
                           input bit poke);
    int cyc;
    expect_sweep(ss, st, nb, dl);
    set_cfg(ss, st, nb, dl);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    cyc = 0;
    while (busy && cyc < 5000) begin
      if (poke) begin
        set_cfg(int'($urandom), int'($urandom), int'($urandom), int'($urandom));
        start = (cyc == 2);
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    check("sweep_terminated", int'(cyc < 5000), 1);
  endtask

  initial begin
    int cfg_tab[4][2] = '{'{100, 0}, '{16800, 5}, '{0, 16800}, '{32767, 32767}};
    int cyc;

    repeat (3) @(posedge clk);
    #1;
    check_reset_values("por");
    reset = 1'b0;
    tick();

    run_sweep(0, 2, 3, 4, 1'b0);
    run_sweep(16000, 1000, 2, 3, 1'b0);
    run_sweep(16799, 1, 2, 1, 1'b0);
    run_sweep(5, 7, 0, 0, 1'b0);

    foreach (cfg_tab[k]) begin
      exp_q.push_back('{EV_CFG, 0, 0, 0});
      set_cfg(cfg_tab[k][0], cfg_tab[k][1], 2, 2);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("cfg_reject_busy", int'(busy), 0);
      tick();
      check("cfg_reject_busy_hold", int'(busy), 0);
    end

    set_cfg(10, 10, 2, 2);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", int'(busy), 0);
    repeat (3) tick();

    // Abort in the second dwell cycle of bin 1.
    exp_q.push_back('{EV_BIN, 0, 100, 3});
    exp_q.push_back('{EV_BIN, 1, 105, 0});
    set_cfg(100, 5, 3, 3);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!(bin_start && bin_index == 10'd1) && cyc < 500) begin
      tick();
      cyc++;
    end
    check("abort_reached_bin1", int'(cyc < 500), 1);
    tick();
    check("abort_in_dwell", int'(acc_enable), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_seek_en", int'(seek_en), 0);
    check("abort_acc_enable", int'(acc_enable), 0);
    check("abort_bin_done", int'(bin_done), 0);
    repeat (8) tick();
    check("abort_idle_hold", int'(busy), 0);
    check("abort_index_hold", int'(bin_index), 1);

    // Reset with start in the same cycle while waiting in SETTLE.
    up_dmin = 6;
    up_dmax = 6;
    set_cfg(1234, 3, 2, 2);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("settle_seek_en", int'(seek_en), 1);
    check("settle_acc_enable", int'(acc_enable), 0);
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    check_reset_values("mid_reset");
    repeat (10) tick();
    check("mid_reset_idle", int'(busy), 0);
    up_dmin = 0;
    up_dmax = 3;

    for (int n = 0; n < 12; n++) begin
      run_sweep(int'($urandom_range(16799, 0)), int'($urandom_range(16799, 1)),
                int'($urandom_range(5, 0)), int'($urandom_range(6, 0)), 1'b1);
      repeat (2) tick();
    end

    repeat (5) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
